// File: rtl/laplace_char_uart_tx.sv
// UART 8N1 transmitter with a small character FIFO, fed by the Laplace LUT stream.
// Optional even-parity bit between data and stop when LAPLACE_UART_TX_PARITY_EN is defined.
module laplace_char_uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef LAPLACE_UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
`ifdef LAPLACE_UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_count_q, fifo_count_d;

    logic              push;
    logic              pop;
    logic              baud_last;
    logic [7:0]        head;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign char_ready = (fifo_count_q < DEPTH_C);
    assign push       = char_valid && char_ready;
    assign head       = mem_q[rd_ptr_q];
    assign baud_last  = (baud_q == BAUD_LAST);

    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE) || (fifo_count_q != '0);
    assign fifo_count = fifo_count_q;
    assign overflow   = overflow_q;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = char_in;
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
        overflow_d = overflow_q || (char_valid && !char_ready);
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;
`ifdef LAPLACE_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (fifo_count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = ST_START;
`ifdef LAPLACE_UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef LAPLACE_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef LAPLACE_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (fifo_count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = ST_START;
`ifdef LAPLACE_UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
`ifdef LAPLACE_UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
`ifdef LAPLACE_UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_laplace_char_uart_tx.sv
// Directed bench for laplace_char_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A free-running line receiver decodes frames; scenario tasks check against hand-computed values.
module tb_laplace_char_uart_tx;

`ifdef LAPLACE_UART_TX_PARITY_EN
    localparam int FRAME = 44;
`else
    localparam int FRAME = 40;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int passed;
    int total;
    int unsigned cyc;
    bit rst_seen;

    logic [7:0]  rx_data[$];
    int unsigned rx_t[$];
    logic        rx_stop[$];
    logic        rx_par[$];

    laplace_char_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .char_in(char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge rst) rst_seen = 1'b1;

    // Line receiver: samples mid-bit, drops frames interrupted by reset.
    initial begin : line_rx
        logic [7:0] d;
        logic       p;
        logic       s;
        int unsigned t0;
        p = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst === 1'b0 && tx === 1'b0) begin
                t0 = cyc;
                rst_seen = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < 8; k++) begin
                    repeat (4) @(posedge clk);
                    #1;
                    d[k] = tx;
                end
`ifdef LAPLACE_UART_TX_PARITY_EN
                repeat (4) @(posedge clk);
                #1;
                p = tx;
`endif
                repeat (4) @(posedge clk);
                #1;
                s = tx;
                if (!rst_seen) begin
                    rx_data.push_back(d);
                    rx_t.push_back(t0);
                    rx_stop.push_back(s);
                    rx_par.push_back(p);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    task automatic clear_rx();
        rx_data.delete();
        rx_t.delete();
        rx_stop.delete();
        rx_par.delete();
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        char_valid = 1'b0;
        char_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
        total++; if (char_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", char_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL reset_idle: got tx=%b busy=%b want 1 0", tx, busy); else passed++;
    endtask

    task automatic test_single();
        logic [7:0]  d;
        logic [11:0] pat;
        int          bad;
        int          busy_cnt;
        bit          to;
        d = 8'h41;
        pat[0] = 1'b0;
        for (int k = 0; k < 8; k++) pat[k+1] = d[k];
`ifdef LAPLACE_UART_TX_PARITY_EN
        pat[9] = 1'b0;
        pat[10] = 1'b1;
`else
        pat[9] = 1'b1;
        pat[10] = 1'b1;
`endif
        pat[11] = 1'b1;
        clear_rx();
        char_in = d;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        total++; if (fifo_count !== 3'd1) $display("FAIL single_count_push: got %0d want 1", fifo_count); else passed++;
        total++; if (tx !== 1'b1 || busy !== 1'b1) $display("FAIL single_push_cycle: got tx=%b busy=%b want 1 1", tx, busy); else passed++;
        bad = 0;
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                total++; if (fifo_count !== 3'd0) $display("FAIL single_count_pop: got %0d want 0", fifo_count); else passed++;
            end
            if (tx !== pat[i/4]) bad++;
            if (busy === 1'b1) busy_cnt++;
        end
        total++; if (bad != 0) $display("FAIL single_waveform: got %0d wrong tx samples want 0", bad); else passed++;
        total++; if (busy_cnt != FRAME) $display("FAIL single_busy_len: got %0d want %0d", busy_cnt, FRAME); else passed++;
        wait_idle(to);
        total++; if (to) $display("FAIL single_idle_timeout: got busy want idle"); else passed++;
        total++; if (rx_data.size() != 1) $display("FAIL single_frames: got %0d want 1", rx_data.size());
        else if (rx_data[0] !== 8'h41 || rx_stop[0] !== 1'b1) $display("FAIL single_rx: got %h stop=%b want 41 1", rx_data[0], rx_stop[0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int  peak;
        int  ready_drops;
        bit  to;
        int unsigned n;
        clear_rx();
        peak = 0;
        ready_drops = 0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            char_in = 8'(8'h10 + i);
            char_valid = 1'b1;
            if (char_ready !== 1'b1) ready_drops++;
            @(posedge clk); #1;
            if (i == 0) n = cyc;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        char_valid = 1'b0;
        total++; if (ready_drops != 0) $display("FAIL b2b_ready: got %0d low cycles want 0", ready_drops); else passed++;
        total++; if (peak != 4) $display("FAIL b2b_peak: got %0d want 4", peak); else passed++;
        wait_idle(to);
        total++; if (to) $display("FAIL b2b_idle_timeout: got busy want idle"); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", overflow); else passed++;
        total++; if (rx_data.size() != 5) $display("FAIL b2b_frames: got %0d want 5", rx_data.size()); else passed++;
        if (rx_t.size() > 0) begin
            total++; if (rx_t[0] != n + 1) $display("FAIL b2b_latency: got %0d want %0d", rx_t[0], n + 1); else passed++;
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            total++; if (rx_data[i] !== 8'(8'h10 + i) || rx_stop[i] !== 1'b1)
                $display("FAIL b2b_data%0d: got %h stop=%b want %h 1", i, rx_data[i], rx_stop[i], 8'(8'h10 + i));
            else passed++;
            if (i > 0) begin
                total++; if (rx_t[i] - rx_t[i-1] != FRAME)
                    $display("FAIL b2b_gap%0d: got %0d want %0d", i, rx_t[i] - rx_t[i-1], FRAME);
                else passed++;
            end
        end
    endtask

    task automatic test_push_pop();
        bit to;
        int unsigned n;
        clear_rx();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            char_in = 8'(8'h51 + i);
            char_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 0) n = cyc;
        end
        char_valid = 1'b0;
        while (cyc < n + 40) begin
            @(posedge clk); #1;
        end
        total++; if (fifo_count !== 3'd2 || tx !== 1'b1) $display("FAIL pp_before: got count=%0d tx=%b want 2 1", fifo_count, tx); else passed++;
        char_in = 8'h54;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        total++; if (fifo_count !== 3'd2) $display("FAIL pp_count: got %0d want 2", fifo_count); else passed++;
        total++; if (tx !== 1'b0) $display("FAIL pp_pop_start: got %b want 0", tx); else passed++;
        wait_idle(to);
        total++; if (to) $display("FAIL pp_idle_timeout: got busy want idle"); else passed++;
        total++; if (rx_data.size() != 4) $display("FAIL pp_frames: got %0d want 4", rx_data.size()); else passed++;
        for (int i = 0; i < rx_data.size(); i++) begin
            total++; if (rx_data[i] !== 8'(8'h51 + i)) $display("FAIL pp_data%0d: got %h want %h", i, rx_data[i], 8'(8'h51 + i)); else passed++;
        end
    endtask

    task automatic test_overflow();
        bit to;
        clear_rx();
        for (int i = 0; i < 6; i++) begin
            char_in = 8'(8'h20 + i);
            char_valid = 1'b1;
            if (i == 5) begin
                total++; if (char_ready !== 1'b0) $display("FAIL ovf_ready: got %b want 0", char_ready); else passed++;
                total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else passed++;
            end
            @(posedge clk); #1;
        end
        char_valid = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else passed++;
        wait_idle(to);
        total++; if (to) $display("FAIL ovf_idle_timeout: got busy want idle"); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else passed++;
        total++; if (rx_data.size() != 5) $display("FAIL ovf_frames: got %0d want 5", rx_data.size()); else passed++;
        for (int i = 0; i < rx_data.size(); i++) begin
            total++; if (rx_data[i] !== 8'(8'h20 + i)) $display("FAIL ovf_data%0d: got %h want %h", i, rx_data[i], 8'(8'h20 + i)); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int unsigned n;
        int lows;
        clear_rx();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            char_in = 8'(8'h61 + i);
            char_valid = 1'b1;
            @(posedge clk); #1;
            if (i == 0) n = cyc;
        end
        char_valid = 1'b0;
        while (cyc < n + 18) begin
            @(posedge clk); #1;
        end
        total++; if (tx !== 1'b0 || fifo_count !== 3'd2) $display("FAIL rmf_bit3: got tx=%b count=%0d want 0 2", tx, fifo_count); else passed++;
        rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1) $display("FAIL rmf_tx_async: got %b want 1", tx); else passed++;
        total++; if (fifo_count !== 3'd0 || busy !== 1'b0) $display("FAIL rmf_async_state: got count=%0d busy=%b want 0 0", fifo_count, busy); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (fifo_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0)
            $display("FAIL rmf_release: got count=%0d busy=%b ovf=%b want 0 0 0", fifo_count, busy, overflow);
        else passed++;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) lows++;
        end
        total++; if (lows != 0) $display("FAIL rmf_quiet: got %0d non-idle samples want 0", lows); else passed++;
        total++; if (rx_data.size() != 0) $display("FAIL rmf_frames: got %0d want 0", rx_data.size()); else passed++;
    endtask

`ifdef LAPLACE_UART_TX_PARITY_EN
    task automatic test_parity();
        bit to;
        clear_rx();
        char_in = 8'h41;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_in = 8'h43;
        @(posedge clk); #1;
        char_valid = 1'b0;
        wait_idle(to);
        total++; if (to) $display("FAIL par_idle_timeout: got busy want idle"); else passed++;
        total++; if (rx_data.size() != 2) $display("FAIL par_frames: got %0d want 2", rx_data.size()); else passed++;
        if (rx_data.size() == 2) begin
            total++; if (rx_data[0] !== 8'h41 || rx_par[0] !== 1'b0) $display("FAIL par_41: got %h p=%b want 41 0", rx_data[0], rx_par[0]); else passed++;
            total++; if (rx_data[1] !== 8'h43 || rx_par[1] !== 1'b1) $display("FAIL par_43: got %h p=%b want 43 1", rx_data[1], rx_par[1]); else passed++;
            total++; if (rx_t[1] - rx_t[0] != 44) $display("FAIL par_len: got %0d want 44", rx_t[1] - rx_t[0]); else passed++;
        end
    endtask
`endif

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        char_valid = 1'b0;
        char_in = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_push_pop();
        test_overflow();
        test_reset_mid_frame();
`ifdef LAPLACE_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
